wb_async_mem_master: RTL



---
 rtl/wb_async_mem_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wb_async_mem_master.sv
// Wishbone classic slave that runs timed CE/OE/WE cycles on an external async SRAM-style bus.
// Setup, strobe and hold lengths are parameters; a synchronized wait input stretches the strobe up to a timeout.
module wb_async_mem_master #(
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sysclk,
  input  logic              reset_switch,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [AW-1:0]     amem_addr_o,
  output logic [DW-1:0]     amem_d_o,
  input  logic [DW-1:0]     amem_d_i,
  output logic              amem_d_oe,
  output logic              amem_ce_n,
  output logic              amem_oe_n,
  output logic              amem_we_n,
  output logic [DW/8-1:0]   amem_be_n,
  input  logic              amem_wait_n_i
);

  localparam int BL = DW / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  // The shared counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYC - 1);

  logic [2:0]    r_state;
  logic [7:0]    r_cnt;
  logic          r_wait_meta;
  logic          r_wait_s;
  logic          r_we;
  logic          r_err_flag;
  logic          r_abort;
  logic          r_ack;
  logic          r_err;
  logic [DW-1:0] r_dat_o;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_d_o;
  logic          r_d_oe;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic [BL-1:0] r_be_n;

  logic w_req;
  logic w_cnt_zero;
  logic w_go_wait;
  logic w_timeout;
  logic w_release;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_go_wait  = (r_state == S_STROBE) & w_cnt_zero & ~r_wait_s;
  assign w_timeout  = (r_state == S_WAIT) & w_cnt_zero & ~r_wait_s;
  assign w_release  = ((r_state == S_STROBE) & w_cnt_zero & r_wait_s) |
                      ((r_state == S_WAIT) & (r_wait_s | w_cnt_zero));

  always_ff @(posedge sysclk or posedge reset_switch) begin
    if (reset_switch) begin
      r_wait_meta <= 1'b1;
      r_wait_s    <= 1'b1;
    end else begin
      r_wait_meta <= amem_wait_n_i;
      r_wait_s    <= r_wait_meta;
    end
  end

  always_ff @(posedge sysclk or posedge reset_switch) begin
    if (reset_switch) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_we       <= 1'b0;
      r_err_flag <= 1'b0;
      r_abort    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat_o    <= '0;
      r_addr     <= '0;
      r_d_o      <= '0;
      r_d_oe     <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_be_n     <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= wb_adr_i;
            r_d_o      <= wb_dat_i;
            r_be_n     <= ~wb_sel_i;
            r_ce_n     <= 1'b0;
            r_d_oe     <= wb_we_i;
            r_we       <= wb_we_i;
            r_abort    <= 1'b0;
            r_err_flag <= 1'b0;
            r_cnt      <= SETUP_LD;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            if (r_we) r_we_n <= 1'b0;
            else      r_oe_n <= 1'b0;
            r_cnt   <= STROBE_LD;
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STROBE, S_WAIT: begin
          if (w_release) begin
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            // A timed-out read leaves the previous read data in place.
            if (!r_we && !w_timeout) r_dat_o <= amem_d_i;
            if (w_timeout) r_err_flag <= 1'b1;
            r_cnt   <= HOLD_LD;
            r_state <= S_HOLD;
          end else if (w_go_wait) begin
            r_cnt   <= TIMEOUT_LD;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_ce_n  <= 1'b1;
            r_be_n  <= '1;
            r_d_oe  <= 1'b0;
            r_ack   <= wb_cyc_i & ~r_abort & ~r_err_flag;
            r_err   <= wb_cyc_i & ~r_abort & r_err_flag;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACK: begin
          r_ack      <= 1'b0;
          r_err      <= 1'b0;
          r_err_flag <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Remember a dropped cycle so a re-raised cyc cannot collect this access's ack.
      if ((r_state != S_IDLE) && (r_state != S_ACK) && !wb_cyc_i)
        r_abort <= 1'b1;
    end
  end

  assign wb_dat_o    = r_dat_o;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign amem_addr_o = r_addr;
  assign amem_d_o    = r_d_o;
  assign amem_d_oe   = r_d_oe;
  assign amem_ce_n   = r_ce_n;
  assign amem_oe_n   = r_oe_n;
  assign amem_we_n   = r_we_n;
  assign amem_be_n   = r_be_n;

endmodule
